pipelined_shifter: RTL and testbench

PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

---
 rtl/shifter_pkg.sv | 12 +
 rtl/shift_stage.sv | 80 ++++++++
 rtl/pipelined_shifter.sv | 72 +++++++
 tb/tb_pipelined_shifter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encoding
// carried down the pipeline alongside each operand.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// One registered level of the shifter: optionally shifts by a fixed distance
// DIST, selected by bit BIT of the travelling shift amount.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int DIST    = 1,
    parameter int BIT     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               valid_i,
    input  logic [WIDTH-1:0]   data_i,
    input  shift_mode_e        mode_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output shift_mode_e        mode_o,
    output logic [SHAMT_W-1:0] shamt_o
);

    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    shift_mode_e        mode_q, mode_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;

    function automatic logic [WIDTH-1:0] shift_by_dist(input logic [WIDTH-1:0] d,
                                                       input shift_mode_e m);
        logic signed [WIDTH-1:0] sd;
        logic [WIDTH-1:0]        res;
        sd = d;
        case (m)
            MODE_SLL: res = d << DIST;
            MODE_SRL: res = d >> DIST;
            MODE_SRA: res = sd >>> DIST;
            default:  res = (d >> DIST) | (d << (WIDTH - DIST));
        endcase
        return res;
    endfunction

    // Data only changes when a valid operand lands, so the output holds its
    // last result while a bubble occupies the stage.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        shamt_d = shamt_q;
        if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d       = shamt_i[BIT] ? shift_by_dist(data_i, mode_i) : data_i;
                mode_d       = mode_i;
                shamt_d      = shamt_i;
                shamt_d[BIT] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= MODE_SLL;
            shamt_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            shamt_q <= shamt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign mode_o  = mode_q;
    assign shamt_o = shamt_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Log-depth pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready
// handshaking and per-stage backpressure that collapses bubbles.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int  WIDTH  = 16,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  Shift_In,
    input  logic [LEVELS-1:0] Shift_Val,
    input  logic [1:0]        Mode,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [WIDTH-1:0]  Shift_Out,
    output logic              Out_Valid,
    input  logic              Out_Ready
);

    // Element 0 is the input port side; element k+1 is the output of stage k.
    logic              valid_s [LEVELS+1];
    logic [WIDTH-1:0]  data_s  [LEVELS+1];
    shift_mode_e       mode_s  [LEVELS+1];
    logic [LEVELS-1:0] shamt_s [LEVELS+1];
    logic [LEVELS-1:0] adv;
    logic [LEVELS-1:0] load;

    assign valid_s[0] = In_Valid;
    assign data_s[0]  = Shift_In;
    assign mode_s[0]  = shift_mode_e'(Mode);
    assign shamt_s[0] = Shift_Val;

    always_comb begin
        adv            = '0;
        load           = '0;
        adv[LEVELS-1]  = Out_Ready;
        for (int k = LEVELS - 2; k >= 0; k--) begin
            adv[k] = !valid_s[k+2] || adv[k+1];
        end
        for (int k = 0; k < LEVELS; k++) begin
            load[k] = !valid_s[k+1] || adv[k];
        end
    end

    // Largest distance first, so stage k consumes shift bit LEVELS-1-k.
    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        shift_stage #(
            .WIDTH  (WIDTH),
            .SHAMT_W(LEVELS),
            .DIST   (1 << (LEVELS - 1 - k)),
            .BIT    (LEVELS - 1 - k)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .load_i (load[k]),
            .valid_i(valid_s[k]),
            .data_i (data_s[k]),
            .mode_i (mode_s[k]),
            .shamt_i(shamt_s[k]),
            .valid_o(valid_s[k+1]),
            .data_o (data_s[k+1]),
            .mode_o (mode_s[k+1]),
            .shamt_o(shamt_s[k+1])
        );
    end

    assign In_Ready  = load[0];
    assign Out_Valid = valid_s[LEVELS];
    assign Shift_Out = data_s[LEVELS];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter at WIDTH=16, plus 32/64-bit regression.
module tb_pipelined_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Shift_In;
    logic [3:0]  Shift_Val;
    logic [1:0]  Mode;
    logic        In_Valid;
    logic        In_Ready;
    logic [15:0] Shift_Out;
    logic        Out_Valid;
    logic        Out_Ready;

    logic [63:0] w_in;
    logic [5:0]  w_val;
    logic [1:0]  w_mode;
    logic        w_vld;
    logic        w_ordy;
    logic        rdy32, ov32, rdy64, ov64;
    logic [31:0] out32;
    logic [63:0] out64;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] q16[$];
    logic [31:0] q32[$];
    logic [63:0] q64[$];

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .Shift_In(Shift_In), .Shift_Val(Shift_Val), .Mode(Mode),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .Shift_Out(Shift_Out),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
    );

    pipelined_shifter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .Shift_In(w_in[31:0]), .Shift_Val(w_val[4:0]), .Mode(w_mode),
        .In_Valid(w_vld), .In_Ready(rdy32), .Shift_Out(out32),
        .Out_Valid(ov32), .Out_Ready(w_ordy)
    );

    pipelined_shifter #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .Shift_In(w_in), .Shift_Val(w_val), .Mode(w_mode),
        .In_Valid(w_vld), .In_Ready(rdy64), .Shift_Out(out64),
        .Out_Valid(ov64), .Out_Ready(w_ordy)
    );

    // Single-step reference: whole shift applied at once on a w-bit value.
    function automatic logic [63:0] model(input logic [63:0] din, input int amt,
                                          input logic [1:0] m, input int w);
        logic [63:0] mask, d, r;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        d = din & mask;
        case (m)
            2'd0: r = (d << amt) & mask;
            2'd1: r = d >> amt;
            2'd2: begin
                r = d >> amt;
                if (d[w-1]) r = r | (mask & ~(mask >> amt));
            end
            default: r = ((d >> amt) | (d << (w - amt))) & mask;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (Out_Valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", Out_Valid); end
        vectors++;
        if (Shift_Out !== 16'h0) begin miscompares++; $display("FAIL rst_shift_out got %h want 0000", Shift_Out); end
        vectors++;
        if (In_Ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", In_Ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  v;
        logic [1:0]  m;
        logic [15:0] e;
    } dvec_t;

    task automatic test_directed();
        dvec_t dv[9];
        int lat;
        dv = '{'{16'h00F1, 4'd4,  2'd0, 16'h0F10},
               '{16'h8000, 4'd15, 2'd1, 16'h0001},
               '{16'h8001, 4'd15, 2'd2, 16'hFFFF},
               '{16'h7FFF, 4'd3,  2'd2, 16'h0FFF},
               '{16'h1234, 4'd4,  2'd3, 16'h4123},
               '{16'hA5C3, 4'd0,  2'd0, 16'hA5C3},
               '{16'hA5C3, 4'd0,  2'd1, 16'hA5C3},
               '{16'hA5C3, 4'd0,  2'd2, 16'hA5C3},
               '{16'hA5C3, 4'd0,  2'd3, 16'hA5C3}};
        Out_Ready = 1'b1;
        foreach (dv[i]) begin
            @(posedge clk); #1;
            In_Valid = 1'b1; Shift_In = dv[i].d; Shift_Val = dv[i].v; Mode = dv[i].m;
            @(negedge clk);
            vectors++;
            if (In_Ready !== 1'b1) begin miscompares++; $display("FAIL dir%0d_accept got %b want 1", i, In_Ready); end
            @(posedge clk); #1;
            In_Valid = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (Out_Valid !== 1'b1 && lat < 12);
            vectors++;
            if (lat != 4) begin miscompares++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
            vectors++;
            if (Shift_Out !== dv[i].e) begin miscompares++; $display("FAIL dir%0d_data got %h want %h", i, Shift_Out, dv[i].e); end
        end
    endtask

    task automatic test_back_to_back();
        int first, nout;
        logic [15:0] exp;
        first = -1; nout = 0;
        q16.delete();
        Out_Ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            In_Valid  = (c < 8);
            Shift_In  = 16'($urandom);
            Shift_Val = 4'($urandom);
            Mode      = 2'($urandom);
            @(negedge clk);
            if (In_Valid) begin
                vectors++;
                if (In_Ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready c%0d got %b want 1", c, In_Ready); end
                else q16.push_back(16'(model({48'b0, Shift_In}, int'(Shift_Val), Mode, 16)));
            end
            if (Out_Valid) begin
                if (first < 0) first = c;
                exp = (q16.size() > 0) ? q16.pop_front() : 16'hxxxx;
                vectors++;
                if (Shift_Out !== exp) begin miscompares++; $display("FAIL b2b_data #%0d got %h want %h", nout, Shift_Out, exp); end
                vectors++;
                if (c != first + nout) begin miscompares++; $display("FAIL b2b_consecutive #%0d got cycle %0d want %0d", nout, c, first + nout); end
                nout++;
            end
        end
        @(posedge clk); #1;
        In_Valid = 1'b0;
        vectors++;
        if (nout != 8) begin miscompares++; $display("FAIL b2b_count got %0d want 8", nout); end
    endtask

    task automatic test_stall();
        int accepts, nout;
        logic [15:0] exp;
        accepts = 0; nout = 0;
        q16.delete();
        @(posedge clk); #1;
        Out_Ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            In_Valid  = 1'b1;
            Shift_In  = 16'($urandom);
            Shift_Val = 4'($urandom);
            Mode      = 2'($urandom);
            @(negedge clk);
            if (In_Ready) begin
                accepts++;
                q16.push_back(16'(model({48'b0, Shift_In}, int'(Shift_Val), Mode, 16)));
            end
        end
        vectors++;
        if (accepts != 4) begin miscompares++; $display("FAIL stall_accepts got %0d want 4", accepts); end
        vectors++;
        if (In_Ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready_low got %b want 0", In_Ready); end
        @(posedge clk); #1;
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        #1;
        vectors++;
        if (In_Ready !== 1'b1) begin miscompares++; $display("FAIL stall_in_ready_return got %b want 1", In_Ready); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (Out_Valid) begin
                exp = (q16.size() > 0) ? q16.pop_front() : 16'hxxxx;
                vectors++;
                if (Shift_Out !== exp) begin miscompares++; $display("FAIL stall_data #%0d got %h want %h", nout, Shift_Out, exp); end
                vectors++;
                if (c != nout) begin miscompares++; $display("FAIL stall_consecutive #%0d got cycle %0d want %0d", nout, c, nout); end
                nout++;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (nout != 4) begin miscompares++; $display("FAIL stall_drain_count got %0d want 4", nout); end
    endtask

    task automatic test_reset_midflight();
        int lat;
        Out_Ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            In_Valid = 1'b1; Shift_In = 16'hF0F0 ^ 16'(c); Shift_Val = 4'd1; Mode = 2'd0;
        end
        @(posedge clk); #1;
        In_Valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (Out_Valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got %b want 0", Out_Valid); end
        vectors++;
        if (Shift_Out !== 16'h0) begin miscompares++; $display("FAIL midrst_shift_out got %h want 0000", Shift_Out); end
        @(posedge clk); #1;
        rst = 1'b0;
        In_Valid = 1'b1; Shift_In = 16'h0123; Shift_Val = 4'd8; Mode = 2'd3;
        @(negedge clk);
        vectors++;
        if (In_Ready !== 1'b1) begin miscompares++; $display("FAIL midrst_accept got %b want 1", In_Ready); end
        @(posedge clk); #1;
        In_Valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (Out_Valid !== 1'b1 && lat < 12);
        vectors++;
        if (lat != 4) begin miscompares++; $display("FAIL midrst_latency got %0d want 4", lat); end
        vectors++;
        if (Shift_Out !== 16'h2301) begin miscompares++; $display("FAIL midrst_data got %h want 2301", Shift_Out); end
    endtask

    task automatic test_wide();
        logic [31:0] e32;
        logic [63:0] e64;
        q32.delete(); q64.delete();
        w_ordy = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            w_vld  = (c < 64);
            w_in   = {$urandom, $urandom};
            w_val  = 6'(c);
            w_mode = 2'($urandom);
            @(negedge clk);
            if (w_vld && rdy32) q32.push_back(32'(model(w_in, int'(w_val[4:0]), w_mode, 32)));
            if (w_vld && rdy64) q64.push_back(model(w_in, int'(w_val), w_mode, 64));
            if (ov32) begin
                e32 = (q32.size() > 0) ? q32.pop_front() : 32'hxxxxxxxx;
                vectors++;
                if (out32 !== e32) begin miscompares++; $display("FAIL w32_data c%0d got %h want %h", c, out32, e32); end
            end
            if (ov64) begin
                e64 = (q64.size() > 0) ? q64.pop_front() : 64'hxxxxxxxxxxxxxxxx;
                vectors++;
                if (out64 !== e64) begin miscompares++; $display("FAIL w64_data c%0d got %h want %h", c, out64, e64); end
            end
        end
        vectors++;
        if (q32.size() != 0 || q64.size() != 0) begin
            miscompares++;
            $display("FAIL wide_leftover got %0d/%0d want 0/0", q32.size(), q64.size());
        end
    endtask

    initial begin
        rst = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b1;
        Shift_In = '0; Shift_Val = '0; Mode = '0;
        w_in = '0; w_val = '0; w_mode = '0; w_vld = 1'b0; w_ordy = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
